// File: rtl/lcd_pixel_feeder_pkg.sv
// Shared types and constants for the LCD pixel feeder: RGB565 field layout, FSM states, fill colour.
// Fill colour selected by LCD_FEEDER_FILL_MAGENTA_EN (magenta when defined, black otherwise).
package lcd_pixel_feeder_pkg;

    localparam int PIX_W = 16;
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        WAIT_SOF     = 2'd0,
        WAIT_FRAME   = 2'd1,
        RUN          = 2'd2,
        RESYNC_FLUSH = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

`ifdef LCD_FEEDER_FILL_MAGENTA_EN
    localparam logic [R_W-1:0] FILL_R = 5'h1F;
    localparam logic [G_W-1:0] FILL_G = 6'h00;
    localparam logic [B_W-1:0] FILL_B = 5'h1F;
`else
    localparam logic [R_W-1:0] FILL_R = 5'h00;
    localparam logic [G_W-1:0] FILL_G = 6'h00;
    localparam logic [B_W-1:0] FILL_B = 5'h00;
`endif

    localparam logic [PIX_W-1:0] FILL_RGB = {FILL_R, FILL_G, FILL_B};

    function automatic rgb565_t unpack_rgb565(input logic [PIX_W-1:0] pix);
        rgb565_t c;
        c.r = pix[R_MSB:R_LSB];
        c.g = pix[G_MSB:G_LSB];
        c.b = pix[B_MSB:B_LSB];
        return c;
    endfunction

endpackage

// File: rtl/lcd_pixel_feeder_if.sv
// Bundle of the feeder's upstream pixel stream, timing inputs, panel outputs and status flags.
interface lcd_pixel_feeder_if;
    import lcd_pixel_feeder_pkg::*;

    logic [PIX_W-1:0] S_DATA;
    logic             S_VALID;
    logic             S_SOF;
    logic             S_READY;
    logic             DE_IN;
    logic             HSYNC_IN;
    logic             VSYNC_IN;
    logic             LCD_DE;
    logic             LCD_HSYNC;
    logic             LCD_VSYNC;
    logic [R_W-1:0]   LCD_R;
    logic [G_W-1:0]   LCD_G;
    logic [B_W-1:0]   LCD_B;
    logic             UNDERFLOW;
    logic             FRAME_ERR;
    logic             CLR_ERR;

    modport master (
        output S_DATA, S_VALID, S_SOF, DE_IN, HSYNC_IN, VSYNC_IN, CLR_ERR,
        input  S_READY, LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B,
               UNDERFLOW, FRAME_ERR
    );

    modport slave (
        input  S_DATA, S_VALID, S_SOF, DE_IN, HSYNC_IN, VSYNC_IN, CLR_ERR,
        output S_READY, LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B,
               UNDERFLOW, FRAME_ERR
    );
endinterface

// File: rtl/lcd_pixel_fifo.sv
// Synchronous show-ahead FIFO (DEPTH x WIDTH) with push, pop and a single-cycle flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module lcd_pixel_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and fill level; flush returns the FIFO to empty in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push, pop})
                2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (level_r == DEPTH_LVL);
    assign empty = (level_r == {(AW+1){1'b0}});
    assign level = level_r;

endmodule

// File: rtl/lcd_pixel_feeder.sv
// Buffers an upstream RGB565 stream and feeds it to an LCD panel in step with the timing generator.
// Fill colour for missing pixels depends on LCD_FEEDER_FILL_MAGENTA_EN.
module lcd_pixel_feeder
    import lcd_pixel_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH   = 64,
    parameter int FRAME_PIXELS = 130560
) (
    input  logic               PixelClk,
    input  logic               RST,
    lcd_pixel_feeder_if.slave  bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    feeder_state_t    state_r;
    feeder_state_t    state_next_s;

    logic             push_s;
    logic             fifo_wr_s;
    logic             fifo_rd_s;
    logic             fifo_flush_s;
    logic [PIX_W-1:0] fifo_rdata_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LVL_W-1:0] fifo_level_s;

    logic [CNT_W-1:0] in_cnt_r;
    logic [CNT_W-1:0] pop_cnt_r;
    logic             frame_edge_s;
    logic             uf_set_s;
    logic             fe_sof_set_s;
    logic             fe_cnt_set_s;

    logic             de_r;
    logic             hsync_r;
    logic             vsync_r;
    logic [PIX_W-1:0] rgb_r;
    logic [PIX_W-1:0] rgb_next_s;
    rgb565_t          rgb_s;
    logic             underflow_r;
    logic             frame_err_r;

    lcd_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk   (PixelClk),
        .rst   (RST),
        .push  (fifo_wr_s),
        .pop   (fifo_rd_s),
        .flush (fifo_flush_s),
        .wdata (bus.S_DATA),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Ready is forced low while reset is held so nothing is handshaken during reset.
    assign bus.S_READY  = ~RST & ~fifo_full_s & (state_r != RESYNC_FLUSH);
    assign push_s       = bus.S_VALID & bus.S_READY;
    // vsync_r holds last cycle's VSYNC_IN sample, so low-then-high is a rising compare.
    assign frame_edge_s = bus.VSYNC_IN & ~vsync_r;

    // FSM state register.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            state_r <= WAIT_SOF;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, FIFO controls and error-set events.
    always_comb begin
        state_next_s = state_r;
        fifo_wr_s    = 1'b0;
        fifo_rd_s    = 1'b0;
        fifo_flush_s = 1'b0;
        uf_set_s     = 1'b0;
        fe_sof_set_s = 1'b0;
        fe_cnt_set_s = 1'b0;
        case (state_r)
            WAIT_SOF: begin
                if (push_s && bus.S_SOF) begin
                    fifo_wr_s    = 1'b1;
                    state_next_s = WAIT_FRAME;
                end else begin
                    state_next_s = WAIT_SOF;
                end
            end
            WAIT_FRAME: begin
                fifo_wr_s = push_s;
                if (frame_edge_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = WAIT_FRAME;
                end
            end
            RUN: begin
                fifo_rd_s    = bus.DE_IN & ~fifo_empty_s;
                // No bypass: a pixel arriving on an empty FIFO cannot cover this DE cycle.
                uf_set_s     = bus.DE_IN & (fifo_level_s == {LVL_W{1'b0}});
                fe_cnt_set_s = frame_edge_s & (pop_cnt_r != FRAME_CNT);
                if (push_s && bus.S_SOF && (in_cnt_r != CNT_ZERO)) begin
                    fe_sof_set_s = 1'b1;
                end else begin
                    fifo_wr_s = push_s;
                end
                if (uf_set_s || fe_sof_set_s) begin
                    state_next_s = RESYNC_FLUSH;
                end else begin
                    state_next_s = RUN;
                end
            end
            RESYNC_FLUSH: begin
                fifo_flush_s = 1'b1;
                state_next_s = WAIT_SOF;
            end
            default: begin
                fifo_flush_s = 1'b1;
                state_next_s = WAIT_SOF;
            end
        endcase
    end

    // Upstream pixel index within the frame, used to validate SOF placement.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            in_cnt_r <= CNT_ZERO;
        end else if (fifo_flush_s) begin
            in_cnt_r <= CNT_ZERO;
        end else if (fifo_wr_s) begin
            in_cnt_r <= (in_cnt_r == FRAME_LAST) ? CNT_ZERO : in_cnt_r + CNT_ONE;
        end
    end

    // Pixels popped since the last frame boundary; only meaningful in RUN.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            pop_cnt_r <= CNT_ZERO;
        end else if (state_r != RUN) begin
            pop_cnt_r <= CNT_ZERO;
        end else if (frame_edge_s) begin
            pop_cnt_r <= fifo_rd_s ? CNT_ONE : CNT_ZERO;
        end else if (fifo_rd_s && (pop_cnt_r != CNT_MAX)) begin
            pop_cnt_r <= pop_cnt_r + CNT_ONE;
        end
    end

    // Sticky error flags; a set event wins over a coincident clear.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            underflow_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (uf_set_s) begin
                underflow_r <= 1'b1;
            end else if (bus.CLR_ERR) begin
                underflow_r <= 1'b0;
            end
            if (fe_sof_set_s || fe_cnt_set_s) begin
                frame_err_r <= 1'b1;
            end else if (bus.CLR_ERR) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    // Pixel selection for the output register: head on pop, fill on a RUN gap, black otherwise.
    always_comb begin
        rgb_next_s = {PIX_W{1'b0}};
        if (bus.DE_IN && (state_r == RUN)) begin
            rgb_next_s = fifo_rd_s ? fifo_rdata_s : FILL_RGB;
        end else begin
            rgb_next_s = {PIX_W{1'b0}};
        end
    end

    // One-stage output pipeline keeping timing and data aligned.
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            de_r    <= 1'b0;
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
            rgb_r   <= {PIX_W{1'b0}};
        end else begin
            de_r    <= bus.DE_IN;
            hsync_r <= bus.HSYNC_IN;
            vsync_r <= bus.VSYNC_IN;
            rgb_r   <= rgb_next_s;
        end
    end

    assign rgb_s         = unpack_rgb565(rgb_r);
    assign bus.LCD_DE    = de_r;
    assign bus.LCD_HSYNC = hsync_r;
    assign bus.LCD_VSYNC = vsync_r;
    assign bus.LCD_R     = rgb_s.r;
    assign bus.LCD_G     = rgb_s.g;
    assign bus.LCD_B     = rgb_s.b;
    assign bus.UNDERFLOW = underflow_r;
    assign bus.FRAME_ERR = frame_err_r;

endmodule

// File: doc/lcd_pixel_feeder.md
LCD_PIXEL_FEEDER -- requirements
Module: lcd_pixel_feeder

Interface
REQ-001: Parameter FIFO_DEPTH, default 64, pixel FIFO entries; power of two, 4 to 1024.
REQ-002: Parameter FRAME_PIXELS, default 130560 (480x272), active pixels per frame.
REQ-003: PixelClk  in  1  pixel clock; the only clock, all logic on its rising edge.
REQ-004: RST  in  1  asynchronous, active-high reset.
REQ-005: S_DATA  in  16  upstream RGB565 pixel: [15:11] R, [10:5] G, [4:0] B.
REQ-006: S_VALID  in  1  S_DATA valid.
REQ-007: S_SOF  in  1  marks the first pixel of a frame; qualified by S_VALID.
REQ-008: S_READY  out  1  feeder accepts a pixel this cycle.
REQ-009: DE_IN, HSYNC_IN, VSYNC_IN  in  1 each  timing from the LCD timing generator; syncs are active-low.
REQ-010: LCD_DE, LCD_HSYNC, LCD_VSYNC  out  1 each  timing delayed to align with pixel data.
REQ-011: LCD_R  out  5, LCD_G  out  6, LCD_B  out  5  panel pixel data.
REQ-012: UNDERFLOW  out  1  sticky; set when DE_IN is high while the FIFO is empty in RUN.
REQ-013: FRAME_ERR  out  1  sticky; set on a pixel-count mismatch at a frame boundary.
REQ-014: CLR_ERR  in  1  synchronous clear of UNDERFLOW and FRAME_ERR.

Function
REQ-015: Push = S_VALID & S_READY; S_READY = !full & (state != RESYNC_FLUSH).
REQ-016: Pop = DE_IN & !empty & state==RUN; data is registered: LCD_R/G/B valid 1 cycle after the DE_IN sample.
REQ-017: DE_IN, HSYNC_IN, VSYNC_IN pass through one register stage, giving exactly 1 cycle latency, matched to data.
REQ-018: Push and pop in the same cycle leave the level unchanged; an empty FIFO has no bypass, so push+DE on empty is an underflow.
REQ-019: Frame boundary = VSYNC_IN sampled low then high.
REQ-020: States: WAIT_SOF, WAIT_FRAME, RUN, RESYNC_FLUSH.
REQ-021: WAIT_SOF: non-SOF pixels are accepted and discarded; a pushed pixel with S_SOF=1 is stored and the state goes to WAIT_FRAME.
REQ-022: WAIT_FRAME: pixels are stored, no pop, output is black; at the next frame boundary the state goes to RUN.
REQ-023: RUN: a pop outputs the FIFO head; when DE_IN is high but there is no pop, output is the fill colour.
REQ-024: RUN, DE_IN=1 and empty: set UNDERFLOW; go to RESYNC_FLUSH.
REQ-025: RUN: a pushed S_SOF pixel that is not pixel 0 of the upstream count sets FRAME_ERR and goes to RESYNC_FLUSH.
REQ-026: RESYNC_FLUSH: one cycle; empties the FIFO and goes to WAIT_SOF.
REQ-027: Pop counter, width ceil(log2(FRAME_PIXELS+1)); at a frame boundary in RUN, count != FRAME_PIXELS sets FRAME_ERR; the counter then clears.
REQ-028: When LCD_DE is low, LCD_R/G/B = 0.
REQ-029: CLR_ERR coinciding with a set event leaves the flag set.

Reset
REQ-030: On RST: state=WAIT_SOF, FIFO empty, counters=0, S_READY=0 while asserted.
REQ-031: On RST: LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0, UNDERFLOW=0, FRAME_ERR=0.
REQ-032: RST mid-frame discards all FIFO contents; there is no partial-frame recovery.

Configuration
REQ-033: Macro LCD_FEEDER_FILL_MAGENTA_EN defined: fill colour (REQ-023) = R 5'h1F, G 6'h00, B 5'h1F; undefined: fill = 0.

Structure
REQ-034: The shared package holds the RGB565 field widths and bit positions, the state enum, and the fill-colour constants.
REQ-035: Sub-module lcd_pixel_fifo: synchronous FIFO (FIFO_DEPTH x 16), push/pop/flush, full/empty/level.

Verification
REQ-036: Reset then SOF pixel 0xF800, frame boundary, DE_IN high -> 1 cycle later LCD_DE=1, R=5'h1F, G=0, B=0.
REQ-037: Upstream sends 130560 pixels per frame over 2 frames -> UNDERFLOW=0, FRAME_ERR=0, output order equals input order.
REQ-038: Stall S_VALID so the FIFO empties while DE_IN=1 -> UNDERFLOW=1, fill colour out (0 or magenta per macro), FIFO flushed, state WAIT_SOF.
REQ-039: Fill the FIFO with 64 pixels and hold DE_IN=0 -> S_READY=0; one pop -> S_READY=1 on the next cycle.
REQ-040: Send 100 pixels before the SOF pixel -> the 100 are discarded; the first displayed pixel is the SOF pixel.
REQ-041: Assert RST mid-frame -> all outputs take their REQ-031 values; after release, no pixel is output until a new SOF and frame boundary.
